// File: rtl/alu_pkg.sv
// Constants and helpers shared by the Kolache ALU blocks.
package alu_pkg;

  localparam int unsigned OperandWidth = 8;

  // Number of leaves in the smallest power-of-two tree with at least n inputs.
  function automatic int unsigned tree_leaves(input int unsigned n);
    int unsigned leaves;
    leaves = 1;
    while (leaves < n) leaves = leaves << 1;
    return leaves;
  endfunction

endpackage

// File: rtl/or_16x1_or2_cell.sv
// Two-input OR cell used as the building block of the reduction tree.
module or2_cell (
  input  logic x,
  input  logic y,
  output logic a
);

  assign a = x | y;

endmodule

// File: rtl/or_16x1.sv
// 2*WIDTH-input OR reduction with a registered result, valid strobe and sticky any-one flag.
module or_16x1
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = OperandWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic             out_valid,
  output logic             sticky
);

  localparam int unsigned NumIn  = 2 * WIDTH;
  localparam int unsigned Leaves = tree_leaves(NumIn);

  logic [NumIn-1:0] cat;
  // Heap layout: node 0 is the root, node k has children 2k+1 and 2k+2,
  // leaves occupy indices Leaves-1 .. 2*Leaves-2.
  logic [2*Leaves-2:0] node;

  assign cat = {a, b};

  for (genvar j = 0; j < Leaves; j++) begin : g_leaf
    if (j < NumIn) begin : g_used
      assign node[Leaves-1+j] = cat[j];
    end else begin : g_pad
      assign node[Leaves-1+j] = 1'b0;
    end
  end

  for (genvar k = 0; k < Leaves - 1; k++) begin : g_cell
    or2_cell u_or2 (
      .x (node[2*k+1]),
      .y (node[2*k+2]),
      .a (node[k])
    );
  end

  assign y = node[0];

  logic res_d, res_q;
  logic vld_d, vld_q;
  logic sticky_d, sticky_q;

  always_comb begin
    res_d    = in_valid ? y : res_q;
    vld_d    = in_valid;
    // Clear has priority over a same-cycle set.
    sticky_d = clr ? 1'b0 : (sticky_q | (in_valid & y));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q    <= 1'b0;
      vld_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      res_q    <= res_d;
      vld_q    <= vld_d;
      sticky_q <= sticky_d;
    end
  end

  assign y_q       = res_q;
  assign out_valid = vld_q;
  assign sticky    = sticky_q;

endmodule

// File: tb/tb_or_16x1.sv
// Directed self-checking bench for or_16x1.
module tb_or_16x1;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_valid = 1'b0;
  logic       clr = 1'b0;
  logic       y, y_q, out_valid, sticky;

  int n_checks = 0;
  int n_fail   = 0;

  or_16x1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .clr       (clr),
    .y         (y),
    .y_q       (y_q),
    .out_valid (out_valid),
    .sticky    (sticky)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       ey;
  } vec_t;

  vec_t vecs[5] = '{
    '{8'hFF, 8'hFF, 1'b1},
    '{8'h00, 8'h00, 1'b0},
    '{8'h0A, 8'h0A, 1'b1},
    '{8'h72, 8'h5B, 1'b1},
    '{8'hFF, 8'h3B, 1'b1}
  };

  initial begin
    logic [15:0] walk;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_y_q", y_q, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_sticky", sticky, 1'b0);

    // Combinational vectors, no clock running.
    for (int i = 0; i < 5; i++) begin
      a = vecs[i].va;
      b = vecs[i].vb;
      #20;
      check_eq($sformatf("comb_%0d", i), y, vecs[i].ey);
    end

    a = 8'h00; b = 8'h00;
    #20;
    check_eq("walk_zero", y, 1'b0);
    for (int i = 0; i < 16; i++) begin
      walk = 16'h0001 << i;
      a = walk[15:8];
      b = walk[7:0];
      #20;
      check_eq($sformatf("walk_%0d", i), y, 1'b1);
    end
    a = 8'h00; b = 8'h00;
    #20;
    check_eq("walk_zero_end", y, 1'b0);

    a = 8'bx000_0001;
    #20;
    check_eq("x_dominated", y, 1'b1);
    a = 8'h00;

    // Registered path.
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; a = 8'h00; b = 8'h00;
    step();
    check_eq("reg0_y_q", y_q, 1'b0);
    check_eq("reg0_out_valid", out_valid, 1'b1);
    check_eq("reg0_sticky", sticky, 1'b0);

    @(negedge clk);
    a = 8'h01;
    step();
    check_eq("reg1_y_q", y_q, 1'b1);
    check_eq("reg1_sticky", sticky, 1'b1);

    @(negedge clk);
    in_valid = 1'b0; a = 8'h00;
    step();
    check_eq("hold_y_q", y_q, 1'b1);
    check_eq("hold_out_valid", out_valid, 1'b0);
    check_eq("hold_sticky", sticky, 1'b1);

    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; a = 8'h80;
    step();
    check_eq("clr_sticky", sticky, 1'b0);
    check_eq("clr_y_q", y_q, 1'b1);

    @(negedge clk);
    clr = 1'b0; a = 8'h00;
    step();
    check_eq("after_clr_sticky", sticky, 1'b0);
    check_eq("after_clr_y_q", y_q, 1'b0);

    // Load all three registers with 1, then pulse reset between edges.
    @(negedge clk);
    a = 8'h00; b = 8'h20;
    step();
    check_eq("pre_rst_y_q", y_q, 1'b1);
    check_eq("pre_rst_sticky", sticky, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    b = 8'h04;
    #1 rst = 1'b1;
    #1;
    check_eq("arst_y_q", y_q, 1'b0);
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_sticky", sticky, 1'b0);
    check_eq("arst_y_one", y, 1'b1);
    b = 8'h00;
    #1;
    check_eq("arst_y_zero", y, 1'b0);
    rst = 1'b0;

    @(negedge clk);
    in_valid = 1'b1; a = 8'h00; b = 8'h00;
    step();
    check_eq("post_rst_y_q", y_q, 1'b0);
    check_eq("post_rst_out_valid", out_valid, 1'b1);
    check_eq("post_rst_sticky", sticky, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/or_16x1.md
Name: or_16x1

Overview:
- 16-input OR reduction for the Kolache ALU: two 8-bit operands in, one bit out (1 if any of the 16 bits is set).
- Primary output y is purely combinational, so it is valid in the same time step as the inputs and needs no clock edge.
- Also provides a registered copy of the result with a valid strobe, plus a sticky "any one seen" flag for the ALU's zero/nonzero status logic.

Parameters:
- WIDTH, 8, bits per operand. Total reduction width is 2*WIDTH. Default 8 gives the 16-input OR.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a and b for the registered path.
- clr  input  1  synchronous clear of the sticky flag.
- y  output  1  combinational OR of all bits of a and b.
- y_q  output  1  registered y, captured when in_valid=1.
- out_valid  output  1  in_valid delayed by one cycle.
- sticky  output  1  set once any valid cycle had y=1; held until clr or rst.

Behaviour:
- y = OR of a[WIDTH-1:0] and b[WIDTH-1:0].
  - Zero latency; no dependence on clk or rst.
  - Must settle within the same time step as an input change.
- y is built as a balanced tree of 2-input OR cells.
  - Level 0 pairs bit i of the concatenation {a,b} with bit i+1.
  - For 16 inputs: 4 levels, 15 cells.
  - For WIDTH values that do not give a power-of-two total, the missing leaves are padded with 0.
- Reset (rst=1, asynchronous): y_q=0, out_valid=0, sticky=0 immediately, independent of clk. y keeps tracking its inputs during reset.
- Each rising clk edge with rst=0:
  - out_valid <= in_valid.
  - If in_valid=1, y_q <= y; otherwise y_q holds its value.
  - sticky <= (clr) ? 0 : (sticky | (in_valid & y)).
- clr and a valid y=1 in the same cycle: clr wins, so sticky=0 next cycle. A sticky set by that cycle's data is not recorded.
- Reset asserted mid-stream clears all registered outputs. The first valid cycle after reset release behaves as if nothing came before it.
- X on any input bit gives X on y unless another bit is 1; a 1 anywhere dominates.

Decomposition:
- Shared package (alu_pkg): the default operand width constant (8) used across ALU blocks.
- Sub-module or2_cell: a = x | y, 2 inputs, 1 output. Instantiated in a generate-built tree.
- The registers (y_q, out_valid, sticky) live in the top module.

Test Plan:
- Combinational, no clock applied. Hold each vector 20 ns and check y:
  - a=8'hFF, b=8'hFF -> y=1.
  - a=8'h00, b=8'h00 -> y=0.
  - a=8'h0A, b=8'h0A -> y=1.
  - a=8'h72, b=8'h5B -> y=1.
  - a=8'hFF, b=8'h3B -> y=1.
- Walking one: a=0, b=0, then set a single bit across all 16 positions.
  - y=1 for every position; y=0 when all bits are 0.
  - Confirms every tree leaf is connected.
- Registered path:
  - With rst released, present a=0, b=0 with in_valid=1 -> next edge: y_q=0, out_valid=1.
  - Then a=8'h01, b=0 with in_valid=1 -> y_q=1, sticky=1.
  - Then drop in_valid -> y_q holds 1, out_valid=0.
- Sticky clear priority:
  - sticky=1, then clr=1 together with a=8'h80 and in_valid=1 -> sticky=0 after the edge.
  - Next valid cycle with a=0, b=0 -> sticky stays 0.
- Asynchronous reset:
  - With y_q=1, out_valid=1, sticky=1, pulse rst between clock edges -> all three go to 0 before the next edge.
  - y continues to equal the OR of the inputs throughout the pulse.
